// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types for the issue controller (package pipe_ctrl_pkg)
//   state_t    : issue FSM states RUN, STALL, DRAIN, HALTED
//   REG_W      : default register address width
//   ZERO_REG   : hardwired-zero register address, honoured when ZERO_REG_EN is defined
//   sb_entry_t : one scoreboard slot {valid, rd}
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage operands, halt handshake and issue-control outputs
//   master : drives id_valid, id_rs1/2(_use), ID_WRegEn, ID_WReg1, halt_req
//   slave  : drives halt_ack, stall, bubble, issue, sb_busy, stall_cycles
interface pipe_hazard_ctrl_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic             id_rs1_use;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs2_use;
  logic             ID_WRegEn;
  logic [REG_W-1:0] ID_WReg1;
  logic             halt_req;
  logic             halt_ack;
  logic             stall;
  logic             bubble;
  logic             issue;
  logic             sb_busy;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs1_use, id_rs2, id_rs2_use, ID_WRegEn, ID_WReg1, halt_req,
    input  halt_ack, stall, bubble, issue, sb_busy, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs1_use, id_rs2, id_rs2_use, ID_WRegEn, ID_WReg1, halt_req,
    output halt_ack, stall, bubble, issue, sb_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: DEPTH-deep shift chain of in-flight writes with RAW compare
//   clk, reset          : clock, synchronous active-high reset
//   push, push_rd       : issued instruction writes push_rd (enters slot 0)
//   id_valid, rs1/rs2   : ID-stage source operands and their use flags
//   hazard              : ID instruction reads a register still in flight
//   busy                : any slot valid
//   ZERO_REG_EN         : when defined, register 0 never enters or matches the chain
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs1_use,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs2_use,
  output logic             hazard,
  output logic             busy
);
  import pipe_ctrl_pkg::*;
  sb_entry_t ent_q [DEPTH];
  sb_entry_t ent_d [DEPTH];
  logic push_ok, use1, use2, hit, any;
`ifdef ZERO_REG_EN
  assign push_ok = push & (push_rd != ZERO_REG);
  assign use1 = rs1_use & (rs1 != ZERO_REG);
  assign use2 = rs2_use & (rs2 != ZERO_REG);
`else
  assign push_ok = push;
  assign use1 = rs1_use;
  assign use2 = rs2_use;
`endif
  always_comb begin
    ent_d[0] = '{valid: push_ok, rd: push_ok ? push_rd : ZERO_REG};
    for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
  end
  always_comb begin
    hit = 1'b0;
    any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any = any | ent_q[k].valid;
      hit = hit | (ent_q[k].valid & ((use1 & (ent_q[k].rd == rs1)) | (use2 & (ent_q[k].rd == rs2))));
    end
  end
  always_ff @(posedge clk)
    if (reset) for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    else ent_q <= ent_d;
  assign hazard = id_valid & hit;
  assign busy = any;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue/stall/bubble controller beside ID/EX with RAW scoreboard and halt/drain
//   clk, reset : clock, synchronous active-high reset
//   bus        : pipe_hazard_ctrl_if.slave (ID operands, halt_req in; halt_ack, stall,
//                bubble, issue, sb_busy, stall_cycles out)
//   ZERO_REG_EN: when defined, register 0 is hardwired zero and never causes a hazard
module pipe_hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hazard, sb_busy, run_like, stall, issue;
  hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .push     (issue & bus.ID_WRegEn),
    .push_rd  (bus.ID_WReg1),
    .id_valid (bus.id_valid),
    .rs1      (bus.id_rs1),
    .rs1_use  (bus.id_rs1_use),
    .rs2      (bus.id_rs2),
    .rs2_use  (bus.id_rs2_use),
    .hazard   (hazard),
    .busy     (sb_busy)
  );
  // halt_req beats hazard: it stops issue and is not counted as a hazard stall
  always_comb begin
    run_like = (state_q == RUN) | (state_q == STALL);
    stall = ~run_like | (run_like & bus.halt_req) | hazard;
    issue = bus.id_valid & ~stall;
    state_d = run_like ? (bus.halt_req ? DRAIN : hazard ? STALL : RUN) :
              (state_q == DRAIN) ? (sb_busy ? DRAIN : HALTED) :
              (bus.halt_req ? HALTED : RUN);
    cnt_d = (run_like & hazard & ~bus.halt_req & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign bus.halt_ack = state_q == HALTED;
  assign bus.stall = stall;
  assign bus.bubble = stall | ~bus.id_valid;
  assign bus.issue = issue;
  assign bus.sb_busy = sb_busy;
  assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic we, input logic [4:0] wd);
    bus.id_valid = v;
    bus.id_rs1 = r1;
    bus.id_rs1_use = u1;
    bus.id_rs2 = r2;
    bus.id_rs2_use = u2;
    bus.ID_WRegEn = we;
    bus.ID_WReg1 = wd;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.halt_req = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    reset = 1'b0;
    #1;
  endtask
  initial begin
    bus.halt_req = 1'b0;
    do_reset;
    chk("rst_halt_ack", bus.halt_ack, 0);
    chk("rst_sb_busy", bus.sb_busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_bubble", bus.bubble, 1);
    chk("rst_issue", bus.issue, 0);
    chk("rst_cnt", bus.stall_cycles, 0);
    // producer r5 then dependent reader: three stall cycles
    drv(1, 0, 0, 0, 0, 1, 5);
    chk("t1_wr_issue", bus.issue, 1);
    tick;
    drv(1, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_stall", bus.stall, 1);
      chk("t1_bubble", bus.bubble, 1);
      chk("t1_no_issue", bus.issue, 0);
      tick;
    end
    chk("t1_issue4", bus.issue, 1);
    chk("t1_stall4", bus.stall, 0);
    chk("t1_cnt", bus.stall_cycles, 3);
    chk("t1_busy", bus.sb_busy, 0);
    tick;
    // independent stream
    do_reset;
    drv(1, 10, 1, 0, 0, 1, 1);
    chk("t2_issue0", bus.issue, 1);
    tick;
    drv(1, 11, 1, 0, 0, 1, 2);
    chk("t2_issue1", bus.issue, 1);
    tick;
    drv(1, 10, 1, 11, 1, 1, 3);
    chk("t2_issue2", bus.issue, 1);
    chk("t2_busy", bus.sb_busy, 1);
    tick;
    chk("t2_cnt", bus.stall_cycles, 0);
    // producer r7, two unrelated, reader of r7: single stall; unused rs1=r8 ignored
    do_reset;
    drv(1, 0, 0, 0, 0, 1, 7);
    tick;
    drv(1, 1, 1, 0, 0, 1, 8);
    chk("t3_unrel1", bus.issue, 1);
    tick;
    drv(1, 2, 1, 0, 0, 1, 9);
    chk("t3_unrel2", bus.issue, 1);
    tick;
    drv(1, 8, 0, 7, 1, 0, 0);
    chk("t3_stall", bus.stall, 1);
    tick;
    chk("t3_issue", bus.issue, 1);
    chk("t3_cnt", bus.stall_cycles, 1);
    tick;
    // halt with two writes in flight; halt_req coincides with a hazard
    do_reset;
    drv(1, 0, 0, 0, 0, 1, 1);
    tick;
    drv(1, 0, 0, 0, 0, 1, 2);
    tick;
    drv(1, 2, 1, 0, 0, 0, 0);
    bus.halt_req = 1'b1;
    #1;
    chk("t4_req_issue", bus.issue, 0);
    chk("t4_req_stall", bus.stall, 1);
    tick;
    chk("t4_cnt_prio", bus.stall_cycles, 0);
    chk("t4_d0_busy", bus.sb_busy, 1);
    chk("t4_d0_ack", bus.halt_ack, 0);
    chk("t4_d0_issue", bus.issue, 0);
    tick;
    chk("t4_d1_busy", bus.sb_busy, 1);
    chk("t4_d1_ack", bus.halt_ack, 0);
    tick;
    chk("t4_d2_busy", bus.sb_busy, 0);
    chk("t4_d2_ack", bus.halt_ack, 0);
    tick;
    chk("t4_ack", bus.halt_ack, 1);
    chk("t4_h_issue", bus.issue, 0);
    chk("t4_h_stall", bus.stall, 1);
    tick;
    chk("t4_hold_ack", bus.halt_ack, 1);
    bus.halt_req = 1'b0;
    #1;
    chk("t4_drop_issue", bus.issue, 0);
    tick;
    chk("t4_resume_ack", bus.halt_ack, 0);
    chk("t4_resume_issue", bus.issue, 1);
    chk("t4_cnt_end", bus.stall_cycles, 0);
    tick;
    // reset in the middle of a stall
    do_reset;
    drv(1, 0, 0, 0, 0, 1, 5);
    tick;
    drv(1, 0, 0, 5, 1, 0, 0);
    chk("t5_stall", bus.stall, 1);
    tick;
    chk("t5_cnt_pre", bus.stall_cycles, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("t5_busy", bus.sb_busy, 0);
    chk("t5_stall_rst", bus.stall, 0);
    chk("t5_cnt", bus.stall_cycles, 0);
    chk("t5_issue", bus.issue, 1);
    tick;
    // register 0 behaviour
    do_reset;
    drv(1, 0, 0, 0, 0, 1, 0);
    tick;
    drv(1, 0, 1, 0, 0, 0, 0);
`ifdef ZERO_REG_EN
    chk("t6_r0_stall", bus.stall, 0);
    chk("t6_r0_issue", bus.issue, 1);
    tick;
    chk("t6_r0_cnt", bus.stall_cycles, 0);
`else
    for (int i = 0; i < 3; i++) begin
      chk("t6_r0_stall", bus.stall, 1);
      tick;
    end
    chk("t6_r0_issue", bus.issue, 1);
    chk("t6_r0_cnt", bus.stall_cycles, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
